// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: ALU opcodes, aluop/funct encodings, forwarding selects.
// Also provides the aluop/funct to ALU opcode decode used at ID/EX capture.
package mips_pkg;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_NOP = 3'd3;
   localparam logic [2:0] ALU_SUB = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   // Unknown R-type functs map to ALU_NOP, which the ALU evaluates as zero.
   function automatic logic [2:0] alu_ctrl(input logic [1:0] aluop, input logic [5:0] funct);
      logic [2:0] op;
      op = ALU_NOP;
      case (aluop)
         ALUOP_ADD: op = ALU_ADD;
         ALUOP_SUB: op = ALU_SUB;
         ALUOP_OR:  op = ALU_OR;
         default: begin
            case (funct)
               FUNCT_ADD: op = ALU_ADD;
               FUNCT_SUB: op = ALU_SUB;
               FUNCT_AND: op = ALU_AND;
               FUNCT_OR:  op = ALU_OR;
               FUNCT_SLT: op = ALU_SLT;
               default:   op = ALU_NOP;
            endcase
         end
      endcase
      return op;
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding mux: EX/MEM beats MEM/WB beats the registered value; r0 never forwarded.
// Latency: combinational. Backpressure: none.
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic [DATA_WIDTH-1:0] reg_data,
   input  logic                  exmem_regwrite,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_regwrite,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic [DATA_WIDTH-1:0] data
);

   fwd_sel_t sel;

   always_comb begin
      sel = FWD_REG;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == addr))
         sel = FWD_EXMEM;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == addr))
         sel = FWD_MEMWB;
   end

   always_comb begin
      case (sel)
         FWD_EXMEM: data = exmem_result;
         FWD_MEMWB: data = memwb_result;
         default:   data = reg_data;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register plus forwarding operand select feeding the ALU; flags load-use hazards to decode.
// Latency 1 cycle; flush > stall > load. Optional macro ID_EX_FWD_EN enables the forwarding muxes.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMM_WIDTH  = 16,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_rs_data,
   input  logic [DATA_WIDTH-1:0] in_rt_data,
   input  logic [IMM_WIDTH-1:0]  in_imm,
   input  logic [REG_ADDR_W-1:0] in_rs_addr,
   input  logic [REG_ADDR_W-1:0] in_rt_addr,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic                  in_alusrc,
   input  logic                  in_regdst,
   input  logic [1:0]            in_aluop,
   input  logic [5:0]            in_funct,
   input  logic                  in_regwrite,
   input  logic                  in_memread,
   input  logic                  in_memwrite,
   input  logic                  in_memtoreg,
   input  logic                  exmem_regwrite,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_regwrite,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [2:0]            alu_op,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_store_data,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic                  out_regwrite,
   output logic                  out_memread,
   output logic                  out_memwrite,
   output logic                  out_memtoreg,
   output logic                  load_use_hazard
);

   logic [DATA_WIDTH-1:0] imm_ext;

   generate
      if (DATA_WIDTH > IMM_WIDTH) begin : g_sext
         assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm};
      end else begin : g_trunc
         // Narrow datapath keeps only the low bits; the sign bit is then irrelevant.
         logic unused_imm;
         assign unused_imm = ^in_imm;
         assign imm_ext    = in_imm[DATA_WIDTH-1:0];
      end
   endgenerate

   logic                  valid_q, regwrite_q, memread_q, memwrite_q, memtoreg_q, alusrc_q;
   logic [2:0]            alu_op_q;
   logic [REG_ADDR_W-1:0] dest_q, rs_addr_q, rt_addr_q;
   logic [DATA_WIDTH-1:0] rs_data_q, rt_data_q, imm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         alu_op_q   <= '0;
         dest_q     <= '0;
         rs_addr_q  <= '0;
         rt_addr_q  <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
      end else if (!stall) begin
         valid_q    <= in_valid;
         regwrite_q <= in_regwrite & in_valid;
         memread_q  <= in_memread  & in_valid;
         memwrite_q <= in_memwrite & in_valid;
         memtoreg_q <= in_memtoreg & in_valid;
         alusrc_q   <= in_alusrc;
         alu_op_q   <= alu_ctrl(in_aluop, in_funct);
         dest_q     <= in_regdst ? in_rd_addr : in_rt_addr;
         rs_addr_q  <= in_rs_addr;
         rt_addr_q  <= in_rt_addr;
         rs_data_q  <= in_rs_data;
         rt_data_q  <= in_rt_data;
         imm_q      <= imm_ext;
      end
   end

   logic [DATA_WIDTH-1:0] rs_fwd, rt_fwd;
   logic                  hazard_src;

`ifdef ID_EX_FWD_EN
   fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
      .addr           (rs_addr_q),
      .reg_data       (rs_data_q),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .data           (rs_fwd)
   );

   fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
      .addr           (rt_addr_q),
      .reg_data       (rt_data_q),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .data           (rt_fwd)
   );

   // Only a load result arrives too late to forward into the next instruction.
   assign hazard_src = memread_q;
`else
   logic unused_fwd;
   assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result, rs_addr_q, rt_addr_q};

   assign rs_fwd = rs_data_q;
   assign rt_fwd = rt_data_q;

   // Without forwarding every in-flight writer must drain before its consumer reads.
   assign hazard_src = regwrite_q;
`endif

   assign alu_a          = rs_fwd;
   assign alu_b          = alusrc_q ? imm_q : rt_fwd;
   assign alu_op         = alu_op_q;
   assign out_store_data = rt_fwd;
   assign out_valid      = valid_q;
   assign out_dest       = dest_q;
   assign out_regwrite   = regwrite_q;
   assign out_memread    = memread_q;
   assign out_memwrite   = memwrite_q;
   assign out_memtoreg   = memtoreg_q;

   assign load_use_hazard = in_valid & valid_q & hazard_src & (dest_q != '0) &
                            ((dest_q == in_rs_addr) | (dest_q == in_rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, ALU decode, immediates, forwarding, hazards, stall/flush.
module tb_id_ex_stage;

   logic       clk = 1'b0;
   logic       rst_n, stall, flush, in_valid;
   logic [7:0] in_rs_data, in_rt_data;
   logic [15:0] in_imm;
   logic [4:0] in_rs_addr, in_rt_addr, in_rd_addr;
   logic       in_alusrc, in_regdst;
   logic [1:0] in_aluop;
   logic [5:0] in_funct;
   logic       in_regwrite, in_memread, in_memwrite, in_memtoreg;
   logic       exmem_regwrite, memwb_regwrite;
   logic [4:0] exmem_rd, memwb_rd;
   logic [7:0] exmem_result, memwb_result;
   logic [7:0] alu_a, alu_b, out_store_data;
   logic [2:0] alu_op;
   logic       out_valid, out_regwrite, out_memread, out_memwrite, out_memtoreg;
   logic [4:0] out_dest;
   logic       load_use_hazard;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_WIDTH(8), .IMM_WIDTH(16), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
      .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
      .in_alusrc(in_alusrc), .in_regdst(in_regdst), .in_aluop(in_aluop), .in_funct(in_funct),
      .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
      .in_memtoreg(in_memtoreg),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_valid(out_valid),
      .out_store_data(out_store_data), .out_dest(out_dest),
      .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
      .out_memtoreg(out_memtoreg), .load_use_hazard(load_use_hazard)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      stall = 0; flush = 0; in_valid = 0;
      in_rs_data = 0; in_rt_data = 0; in_imm = 0;
      in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
      in_alusrc = 0; in_regdst = 0; in_aluop = 0; in_funct = 0;
      in_regwrite = 0; in_memread = 0; in_memwrite = 0; in_memtoreg = 0;
      exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({out_valid, out_regwrite, out_memread, out_memwrite, out_memtoreg} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl got %b exp 00000",
            {out_valid, out_regwrite, out_memread, out_memwrite, out_memtoreg});
      end
      n_cmp++;
      if ({alu_op, out_dest, alu_a, alu_b} !== 24'h0) begin
         n_fail++; $display("FAIL reset_data got op=%0d dest=%0d a=%h b=%h exp all 0",
            alu_op, out_dest, alu_a, alu_b);
      end
      rst_n = 1;
      // Load a store-like instruction with every control bit set, then reset mid-cycle.
      in_valid = 1; in_regwrite = 1; in_memread = 1; in_memwrite = 1; in_memtoreg = 1;
      in_aluop = 2'b01; in_rt_addr = 5'd9;
      tick;
      n_cmp++;
      if ({out_valid, out_regwrite, out_memread, out_memwrite, alu_op} !== {4'b1111, 3'd6}) begin
         n_fail++; $display("FAIL pre_reset_load got %b exp 1111110",
            {out_valid, out_regwrite, out_memread, out_memwrite, alu_op});
      end
      #2 rst_n = 0;
      #1;
      n_cmp++;
      if ({out_valid, out_regwrite, out_memread, out_memwrite, out_memtoreg, alu_op, out_dest} !== 13'b0) begin
         n_fail++; $display("FAIL async_reset got v=%b rw=%b mr=%b mw=%b op=%0d dest=%0d exp all 0",
            out_valid, out_regwrite, out_memread, out_memwrite, alu_op, out_dest);
      end
      #1 rst_n = 1;
      clear_inputs;
   endtask

   task automatic test_rtype_add;
      in_valid = 1; in_aluop = 2'b10; in_funct = 6'b100000; in_regwrite = 1;
      in_rs_data = 8'd5; in_rt_data = 8'd3; in_rs_addr = 5'd1; in_rt_addr = 5'd2;
      in_rd_addr = 5'd10; in_regdst = 1; in_alusrc = 0;
      tick;
      n_cmp++;
      if ({alu_op, alu_a, alu_b, out_dest} !== {3'd2, 8'd5, 8'd3, 5'd10}) begin
         n_fail++; $display("FAIL rtype_add got op=%0d a=%0d b=%0d dest=%0d exp op=2 a=5 b=3 dest=10",
            alu_op, alu_a, alu_b, out_dest);
      end
      n_cmp++;
      if ({out_valid, out_regwrite, out_memread} !== 3'b110) begin
         n_fail++; $display("FAIL rtype_ctrl got %b exp 110", {out_valid, out_regwrite, out_memread});
      end
      clear_inputs;
   endtask

   task automatic test_immediate;
      in_valid = 1; in_aluop = 2'b00; in_alusrc = 1; in_imm = 16'hFFFE;
      in_rt_addr = 5'd3; in_rt_data = 8'h44; in_regdst = 0; in_funct = 6'b100010;
      tick;
      n_cmp++;
      if ({alu_b, alu_op, out_dest, out_store_data} !== {8'hFE, 3'd2, 5'd3, 8'h44}) begin
         n_fail++; $display("FAIL imm_neg got b=%h op=%0d dest=%0d sd=%h exp b=fe op=2 dest=3 sd=44",
            alu_b, alu_op, out_dest, out_store_data);
      end
      in_imm = 16'h0181;
      tick;
      n_cmp++;
      if (alu_b !== 8'h81) begin
         n_fail++; $display("FAIL imm_trunc got %h exp 81", alu_b);
      end
      in_alusrc = 0; in_aluop = 2'b10; in_funct = 6'h3F;
      tick;
      n_cmp++;
      if ({alu_op, alu_b} !== {3'd3, 8'h44}) begin
         n_fail++; $display("FAIL unknown_funct got op=%0d b=%h exp op=3 b=44", alu_op, alu_b);
      end
      clear_inputs;
   endtask

   // One decode per cycle, each checked one cycle later.
   task automatic test_back_to_back;
      logic [1:0] aluops [6] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
      logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [2:0] exp_op [6] = '{3'd6, 3'd1, 3'd6, 3'd0, 3'd1, 3'd7};
      in_valid = 1;
      for (int i = 0; i < 6; i++) begin
         in_aluop = aluops[i]; in_funct = functs[i]; in_rs_data = 8'(i + 8'h20);
         tick;
         n_cmp++;
         if ({alu_op, alu_a} !== {exp_op[i], 8'(i + 8'h20)}) begin
            n_fail++; $display("FAIL b2b_%0d got op=%0d a=%h exp op=%0d a=%h",
               i, alu_op, alu_a, exp_op[i], 8'(i + 8'h20));
         end
      end
      clear_inputs;
   endtask

   task automatic test_forward;
      logic [7:0] e_a1, e_a2, e_b3, e_a4;
`ifdef ID_EX_FWD_EN
      e_a1 = 8'h11; e_a2 = 8'h22; e_b3 = 8'h11; e_a4 = 8'h33;
`else
      e_a1 = 8'h33; e_a2 = 8'h33; e_b3 = 8'h55; e_a4 = 8'h33;
`endif
      in_valid = 1; in_rs_addr = 5'd4; in_rs_data = 8'h33; in_rt_addr = 5'd6; in_rt_data = 8'h55;
      tick;
      exmem_regwrite = 1; exmem_rd = 5'd4; exmem_result = 8'h11;
      memwb_regwrite = 1; memwb_rd = 5'd4; memwb_result = 8'h22;
      #1;
      n_cmp++;
      if (alu_a !== e_a1) begin
         n_fail++; $display("FAIL fwd_exmem_prio got %h exp %h", alu_a, e_a1);
      end
      exmem_rd = 5'd0;
      #1;
      n_cmp++;
      if (alu_a !== e_a2) begin
         n_fail++; $display("FAIL fwd_memwb got %h exp %h", alu_a, e_a2);
      end
      exmem_rd = 5'd6;
      #1;
      n_cmp++;
      if ({alu_b, out_store_data, alu_a} !== {e_b3, e_b3, e_a2}) begin
         n_fail++; $display("FAIL fwd_rt got b=%h sd=%h a=%h exp b=%h sd=%h a=%h",
            alu_b, out_store_data, alu_a, e_b3, e_b3, e_a2);
      end
      exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 5'd4;
      #1;
      n_cmp++;
      if ({alu_a, alu_b} !== 16'h3355) begin
         n_fail++; $display("FAIL fwd_no_regwrite got a=%h b=%h exp a=33 b=55", alu_a, alu_b);
      end
      // r0 must never pick up a forwarded value.
      in_rs_addr = 5'd0;
      tick;
      exmem_regwrite = 1; exmem_rd = 5'd0; memwb_regwrite = 1; memwb_rd = 5'd0;
      #1;
      n_cmp++;
      if (alu_a !== e_a4) begin
         n_fail++; $display("FAIL fwd_r0 got %h exp %h", alu_a, e_a4);
      end
      clear_inputs;
   endtask

   task automatic test_load_use;
      logic e_alu_hz;
`ifdef ID_EX_FWD_EN
      e_alu_hz = 1'b0;
`else
      e_alu_hz = 1'b1;
`endif
      in_valid = 1; in_memread = 1; in_regwrite = 1; in_memtoreg = 1;
      in_regdst = 0; in_rt_addr = 5'd7; in_aluop = 2'b00; in_alusrc = 1;
      tick;
      in_memread = 0; in_memtoreg = 0; in_rs_addr = 5'd1; in_rt_addr = 5'd7;
      #1;
      n_cmp++;
      if (load_use_hazard !== 1'b1) begin
         n_fail++; $display("FAIL load_use_rt got %b exp 1", load_use_hazard);
      end
      in_rt_addr = 5'd2; in_rs_addr = 5'd7;
      #1;
      n_cmp++;
      if (load_use_hazard !== 1'b1) begin
         n_fail++; $display("FAIL load_use_rs got %b exp 1", load_use_hazard);
      end
      in_valid = 0;
      #1;
      n_cmp++;
      if (load_use_hazard !== 1'b0) begin
         n_fail++; $display("FAIL load_use_invalid got %b exp 0", load_use_hazard);
      end
      // ALU writer to r7: only a hazard when no forwarding path exists.
      in_valid = 1; in_rt_addr = 5'd7; in_rs_addr = 5'd7; in_memread = 0;
      tick;
      n_cmp++;
      if (load_use_hazard !== e_alu_hz) begin
         n_fail++; $display("FAIL alu_dep_hazard got %b exp %b", load_use_hazard, e_alu_hz);
      end
      in_memread = 1; in_rt_addr = 5'd0;
      tick;
      in_memread = 0; in_rs_addr = 5'd0; in_rt_addr = 5'd0;
      #1;
      n_cmp++;
      if (load_use_hazard !== 1'b0) begin
         n_fail++; $display("FAIL load_use_r0 got %b exp 0", load_use_hazard);
      end
      clear_inputs;
   endtask

   task automatic test_stall_flush;
      in_valid = 1; in_regwrite = 1; in_aluop = 2'b01; in_rs_data = 8'd9; in_rt_data = 8'd4;
      in_rd_addr = 5'd12; in_regdst = 1;
      tick;
      stall = 1; in_aluop = 2'b11; in_valid = 0; in_rd_addr = 5'd1; in_rs_data = 8'd77;
      tick;
      tick;
      n_cmp++;
      if ({alu_op, out_dest, out_valid, out_regwrite, alu_a} !== {3'd6, 5'd12, 1'b1, 1'b1, 8'd9}) begin
         n_fail++; $display("FAIL stall_hold got op=%0d dest=%0d v=%b rw=%b a=%0d exp op=6 dest=12 v=1 rw=1 a=9",
            alu_op, out_dest, out_valid, out_regwrite, alu_a);
      end
      flush = 1; in_valid = 1; in_regwrite = 1; in_memread = 1; in_memwrite = 1;
      tick;
      n_cmp++;
      if ({out_valid, out_regwrite, out_memread, out_memwrite, out_memtoreg} !== 5'b0) begin
         n_fail++; $display("FAIL stall_flush got %b exp 00000",
            {out_valid, out_regwrite, out_memread, out_memwrite, out_memtoreg});
      end
      clear_inputs;
      tick;
   endtask

   initial begin
      clear_inputs;
      rst_n = 0;
      #12;
      test_reset;
      test_rtype_add;
      test_immediate;
      test_back_to_back;
      test_forward;
      test_load_use;
      test_stall_flush;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-select stage directly upstream of the ALU in the MIPS pipeline.
- Captures decoded operands and control each cycle and derives the 3-bit ALU opcode from aluop/funct.
- Resolves EX/MEM and MEM/WB forwarding and drives the ALU a, b and op inputs.
- Flags load-use hazards back to decode.

Parameters:
- DATA_WIDTH, 8, operand/result width; matches ALU width.
- IMM_WIDTH, 16, raw immediate width from decode.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all stage registers
- flush  in  1  replace captured instruction with bubble
- in_valid  in  1  decode slot holds a real instruction
- in_rs_data, in_rt_data  in  DATA_WIDTH  register-file read data
- in_imm  in  IMM_WIDTH  raw immediate
- in_rs_addr, in_rt_addr, in_rd_addr  in  REG_ADDR_W  register numbers
- in_alusrc  in  1  1 = immediate to b
- in_regdst  in  1  1 = rd is destination, 0 = rt is destination
- in_aluop  in  2  00 add, 01 sub, 10 use funct, 11 or
- in_funct  in  6  R-type funct field
- in_regwrite, in_memread, in_memwrite, in_memtoreg  in  1 each  downstream control
- exmem_regwrite  in  1  EX/MEM forwarding source
- exmem_rd  in  REG_ADDR_W  EX/MEM forwarding source
- exmem_result  in  DATA_WIDTH  EX/MEM forwarding source
- memwb_regwrite  in  1  MEM/WB forwarding source
- memwb_rd  in  REG_ADDR_W  MEM/WB forwarding source
- memwb_result  in  DATA_WIDTH  MEM/WB forwarding source
- alu_a, alu_b  out  DATA_WIDTH  ALU operands
- alu_op  out  3  ALU opcode
- out_valid  out  1  stage holds a real instruction
- out_store_data  out  DATA_WIDTH  forwarded rt value for sw
- out_dest  out  REG_ADDR_W  selected destination register
- out_regwrite, out_memread, out_memwrite, out_memtoreg  out  1 each  registered control
- load_use_hazard  out  1  combinational request for decode to stall

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: every stage register cleared to 0. Hence out_valid=0, all control outputs=0, out_dest=0, alu_op=0, and operands equal the forwarding-mux result of zeroed registers.
- Latency: 1 cycle; inputs sampled at a clk rising edge appear on outputs after that edge.
- Update priority per edge is flush > stall > load:
  - flush: valid and all control registers cleared; data registers don't-care (implementation clears them).
  - stall: all registers hold.
  - load: capture inputs; control captured as in_x & in_valid.
- ALU control, computed at capture and stored as a 3-bit register:
  - aluop 00 -> 2 (add); 01 -> 6 (sub); 11 -> 1 (or).
  - aluop 10 uses funct: 100000 -> 2, 100010 -> 6, 100100 -> 0, 100101 -> 1, 101010 -> 7.
  - Any other funct -> 3, which the ALU yields as 0.
- Immediate: sign-extended from bit IMM_WIDTH-1, then the low DATA_WIDTH bits are used; pure truncation when DATA_WIDTH < IMM_WIDTH.
- out_dest = in_regdst ? rd : rt, captured at load.
- Forwarding (combinational on registered addresses), rs and rt paths independently:
  - EX/MEM wins when exmem_regwrite, exmem_rd != 0 and exmem_rd equals the address.
  - Otherwise MEM/WB under the same rule.
  - Otherwise the registered value.
  - Register 0 is never forwarded.
- alu_a is the forwarded rs value.
- alu_b is the registered immediate when alusrc = 1, else the forwarded rt value.
- out_store_data is always the forwarded rt value.
- load_use_hazard = in_valid & out_valid & out_memread & out_dest != 0 & (out_dest == in_rs_addr | out_dest == in_rt_addr). Decode responds with stall upstream plus a bubble here (flush).
- Simultaneous stall and flush: flush wins.
- Reset mid-operation: immediate clear, with no edge required.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding muxes present as described above.
- Undefined: alu_a, alu_b and out_store_data come from registered values only. Forwarding ports remain but are ignored. load_use_hazard is then asserted for any valid out_regwrite destination match, not just loads, so decode stalls full-duration.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOP=3.
  - aluop encodings and funct constants.
  - A forwarding-select enum (FWD_REG, FWD_EXMEM, FWD_MEMWB).
- One natural sub-module, fwd_mux: a single-operand forwarding priority mux, instantiated twice (rs, rt).

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid, out_regwrite, out_memread, out_memwrite and alu_op are 0 immediately, without a clock edge.
- R-type add: aluop=10, funct=100000, rs=5, rt=3, alusrc=0, in_valid=1 -> next cycle alu_op=2, alu_a=5, alu_b=3, out_dest=rd.
- Immediate: aluop=00, alusrc=1, imm=0xFFFE, DATA_WIDTH=8 -> alu_b=0xFE, alu_op=2; unknown funct 0x3F with aluop=10 -> alu_op=3.
- Forward priority: rs_addr=4, exmem_rd=4 (result 0x11) and memwb_rd=4 (result 0x22), both regwrite -> alu_a=0x11; with exmem_rd=0 -> alu_a=0x22.
- Load-use: stage holds lw with dest=7, in_rt_addr=7, in_valid=1 -> load_use_hazard=1; with dest=0 -> 0.
- Stall/flush: stall=1 for 2 cycles -> outputs unchanged; stall=1 with flush=1 -> out_valid=0 and control 0 after edge.
